moving_average_scheduler: RTL

MOVING_AVERAGE_SCHEDULER -- requirements
Module: moving_average_scheduler

---
 rtl/moving_average_scheduler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/moving_average_scheduler.sv
// Round-robin scheduler that accepts one sample per cycle from N_CH channels and
// returns the channel's running average over its last 2^n samples. Empty slots in a
// channel's window count as zero.
module moving_average_scheduler #(
  parameter int N_CH       = 4,
  parameter int n          = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_CH-1:0]              req_valid,
  input  logic [N_CH*DATA_WIDTH-1:0]   req_data,
  output logic [N_CH-1:0]              req_ready,
  input  logic                         clr_valid,
  input  logic [$clog2(N_CH)-1:0]      clr_ch,
  output logic                         avg_valid,
  input  logic                         avg_ready,
  output logic [$clog2(N_CH)-1:0]      avg_ch,
  output logic [DATA_WIDTH-1:0]        avg_data,
  output logic                         avg_full
);

  localparam int CW = $clog2(N_CH);
  localparam int W  = 1 << n;
  localparam int AW = DATA_WIDTH + n;

  logic [CW-1:0]                last_grant;
  logic signed [AW-1:0]         acc  [N_CH];
  logic signed [DATA_WIDTH-1:0] ring [N_CH][W];
  logic [n-1:0]                 wptr [N_CH];
  logic [n:0]                   fill [N_CH];

  logic                         can_issue;
  logic [N_CH-1:0]              eligible;
  logic                         gnt_any;
  logic [CW-1:0]                gnt_ch;
  logic                         xfer;
  int                           scan;
  logic signed [DATA_WIDTH-1:0] d_sel;
  logic signed [DATA_WIDTH-1:0] d_old;
  logic signed [AW-1:0]         acc_new;
  logic signed [AW-1:0]         avg_shift;
  logic [n:0]                   fill_new;

  assign can_issue = !avg_valid || avg_ready;

  // A channel being cleared this cycle cannot also be granted.
  always_comb begin
    eligible = '0;
    for (int c = 0; c < N_CH; c++)
      eligible[c] = req_valid[c] && !(clr_valid && (clr_ch == CW'(c)));
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    req_ready = '0;
    gnt_any   = 1'b0;
    gnt_ch    = '0;
    scan      = 0;
    for (int i = 1; i <= N_CH; i++) begin
      scan = (int'(last_grant) + i) % N_CH;
      if (!gnt_any && eligible[scan[CW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_ch  = scan[CW-1:0];
      end
    end
    xfer = reset_n && can_issue && gnt_any;
    if (xfer)
      req_ready[gnt_ch] = 1'b1;
  end

  // Sliding-window update: drop the oldest ring entry, add the new sample.
  always_comb begin
    d_sel     = req_data[gnt_ch*DATA_WIDTH +: DATA_WIDTH];
    d_old     = ring[gnt_ch][wptr[gnt_ch]];
    acc_new   = acc[gnt_ch] - AW'(d_old) + AW'(d_sel);
    avg_shift = acc_new >>> n;
    fill_new  = (fill[gnt_ch] == (n+1)'(W)) ? fill[gnt_ch] : fill[gnt_ch] + 1'b1;
  end

  // Channel state, arbitration pointer and the registered result slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++) begin
        acc[c]  <= '0;
        wptr[c] <= '0;
        fill[c] <= '0;
        for (int k = 0; k < W; k++)
          ring[c][k] <= '0;
      end
      last_grant <= CW'(N_CH - 1);
      avg_valid  <= 1'b0;
      avg_ch     <= '0;
      avg_data   <= '0;
      avg_full   <= 1'b0;
    end else begin
      if (clr_valid) begin
        acc[clr_ch]  <= '0;
        wptr[clr_ch] <= '0;
        fill[clr_ch] <= '0;
        for (int k = 0; k < W; k++)
          ring[clr_ch][k] <= '0;
      end
      if (xfer) begin
        acc[gnt_ch]               <= acc_new;
        ring[gnt_ch][wptr[gnt_ch]] <= d_sel;
        wptr[gnt_ch]              <= wptr[gnt_ch] + 1'b1;
        fill[gnt_ch]              <= fill_new;
        last_grant                <= gnt_ch;
        avg_valid                 <= 1'b1;
        avg_ch                    <= gnt_ch;
        avg_data                  <= avg_shift[DATA_WIDTH-1:0];
        avg_full                  <= (fill_new == (n+1)'(W));
      end else if (avg_ready) begin
        avg_valid <= 1'b0;
      end
    end
  end

endmodule
